// File: rtl/scalar_wb_arbiter.sv
// Scalar register-file writeback arbiter: loads win, losing ALU results queue in an in-order FIFO.
// One-cycle registered output; optional counters under SCALAR_WB_STATS_EN.
module scalar_wb_arbiter #(
    parameter int N        = 32,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [N-1:0]      mem_data,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [N-1:0]      alu_data,
    output logic              alu_ready,
    output logic              WBSelect,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [N-1:0]      WD3_SCA,
`ifdef SCALAR_WB_STATS_EN
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       stall_cnt,
`endif
    output logic              wb_pending
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fifo_rd_q  [DEPTH];
    logic [N-1:0]      fifo_dat_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              we_q, we_d, sel_q, sel_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [N-1:0]      wd_q, wd_d;

    logic              accept, push, pop, issue, iss_sel;
    logic [ADDR_W-1:0] iss_rd;
    logic [N-1:0]      iss_dat;

    assign alu_ready  = (count_q < CNT_W'(DEPTH));
    assign wb_pending = (count_q != '0);
    assign accept     = alu_valid && alu_ready;
    // Any accepted result that cannot go straight out joins the tail to keep ALU order.
    assign push       = accept && (mem_valid || wb_pending);

    always_comb begin
        issue   = 1'b0;
        iss_sel = 1'b0;
        iss_rd  = mem_rd;
        iss_dat = mem_data;
        pop     = 1'b0;
        if (mem_valid) begin
            issue = 1'b1;
        end else if (wb_pending) begin
            issue   = 1'b1;
            iss_sel = 1'b1;
            iss_rd  = fifo_rd_q[rd_ptr_q];
            iss_dat = fifo_dat_q[rd_ptr_q];
            pop     = 1'b1;
        end else if (accept) begin
            issue   = 1'b1;
            iss_sel = 1'b1;
            iss_rd  = alu_rd;
            iss_dat = alu_data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        we_d     = issue && !((ZERO_REG != 0) && (iss_rd == '0));
        sel_d    = issue ? iss_sel : sel_q;
        a3_d     = issue ? iss_rd  : a3_q;
        wd_d     = issue ? iss_dat : wd_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            sel_q    <= 1'b0;
            a3_q     <= '0;
            wd_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            a3_q     <= a3_d;
            wd_q     <= wd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]  <= alu_rd;
            fifo_dat_q[wr_ptr_q] <= alu_data;
        end
    end

    assign WE3      = we_q;
    assign WBSelect = sel_q;
    assign A3       = a3_q;
    assign WD3_SCA  = wd_q;

`ifdef SCALAR_WB_STATS_EN
    logic [15:0] conflict_q, stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_q <= '0;
            stall_q    <= '0;
        end else begin
            if (push && (conflict_q != 16'hFFFF)) conflict_q <= conflict_q + 16'd1;
            if (alu_valid && !alu_ready && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
    assign stall_cnt    = stall_q;
`endif
endmodule
